// File: rtl/proc_pkg.sv
// Shared constants and types for the proc control unit: instruction format,
// opcode encodings and the four time steps.
package proc_pkg;

  localparam int IRW  = 9;
  localparam int NREG = 8;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; used for the register in/out selects.
module dec3to8 (
  input  logic [2:0] w_i,
  input  logic       en_i,
  output logic [7:0] y_o
);

  assign y_o = en_i ? (8'b0000_0001 << w_i) : 8'b0000_0000;

endmodule

// File: rtl/proc_control.sv
// Control sequencer for the bus-based proc: a 2-bit time-step counter plus a
// combinational decode of (step, IR, Run, G_nz) into datapath enables.
module proc_control
  import proc_pkg::*;
#(
  parameter int NREG = proc_pkg::NREG,
  parameter int IRW  = proc_pkg::IRW
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IRW-1:0]  IR,
  input  logic            G_nz,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Gout,
  output logic            Ain,
  output logic            Gin,
  output logic            AddSub,
  output logic            Done,
  output logic [1:0]      step
);

  tstep_e tstep_q, tstep_d;

  logic [2:0] opcode, rx, ry;
  logic [2:0] rout_sel;
  logic       rin_en, rout_en;
  logic       irin_c, dinout_c, gout_c, ain_c, gin_c, addsub_c, done_c;
  logic [7:0] rin_oh, rout_oh;

  assign opcode = IR[8:6];
  assign rx     = IR[5:3];
  assign ry     = IR[2:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) tstep_q <= T0;
    else         tstep_q <= tstep_d;
  end

  always_comb begin
    tstep_d  = tstep_q;
    irin_c   = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = ry;
    dinout_c = 1'b0;
    gout_c   = 1'b0;
    ain_c    = 1'b0;
    gin_c    = 1'b0;
    addsub_c = 1'b0;
    done_c   = 1'b0;
    unique case (tstep_q)
      T0: begin
        if (Run) begin
          irin_c  = 1'b1;
          tstep_d = T1;
        end
      end
      T1: begin
        tstep_d = T0;
        unique case (opcode)
          OP_MV: begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            done_c  = 1'b1;
          end
          OP_MVI: begin
            dinout_c = 1'b1;
            rin_en   = 1'b1;
            done_c   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_sel = rx;
            rout_en  = 1'b1;
            ain_c    = 1'b1;
            tstep_d  = T2;
          end
          OP_MVNZ: begin
            rout_en = G_nz;
            rin_en  = G_nz;
            done_c  = 1'b1;
          end
          default: done_c = 1'b1;
        endcase
      end
      T2: begin
        rout_en  = 1'b1;
        gin_c    = 1'b1;
        addsub_c = (opcode == OP_SUB);
        tstep_d  = T3;
      end
      T3: begin
        gout_c  = 1'b1;
        rin_en  = 1'b1;
        done_c  = 1'b1;
        tstep_d = T0;
      end
      default: tstep_d = T0;
    endcase
  end

  // Decoder enables and all strobes are qualified by Resetn so every output
  // reads 0 while reset is held, even though T0 with Run=1 would assert IRin.
  dec3to8 u_dec_rin (
    .w_i  (rx),
    .en_i (rin_en & Resetn),
    .y_o  (rin_oh)
  );

  dec3to8 u_dec_rout (
    .w_i  (rout_sel),
    .en_i (rout_en & Resetn),
    .y_o  (rout_oh)
  );

  assign Rin    = rin_oh;
  assign Rout   = rout_oh;
  assign IRin   = irin_c   & Resetn;
  assign DINout = dinout_c & Resetn;
  assign Gout   = gout_c   & Resetn;
  assign Ain    = ain_c    & Resetn;
  assign Gin    = gin_c    & Resetn;
  assign AddSub = addsub_c & Resetn;
  assign Done   = done_c   & Resetn;
  assign step   = tstep_q;

`ifndef SYNTHESIS
  bus_excl_a : assert property (@(posedge Clock) $onehot0({Rout, Gout, DINout}));
`endif

endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: vector table, reset corner cases and
// a randomised run against an independent step-level reference model.
module tb_proc_control;

  typedef struct packed {
    logic [1:0] step;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       gout;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
  } out_t;

  typedef struct packed {
    logic       run;
    logic [8:0] ir;
    logic       gnz;
    out_t       exp;
  } vec_t;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       G_nz;
  logic       IRin, DINout, Gout, Ain, Gin, AddSub, Done;
  logic [7:0] Rin, Rout;
  logic [1:0] step;

  out_t exp_q[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  localparam out_t Z = '0;

  proc_control dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .IR     (IR),
    .G_nz   (G_nz),
    .IRin   (IRin),
    .Rin    (Rin),
    .Rout   (Rout),
    .DINout (DINout),
    .Gout   (Gout),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done),
    .step   (step)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic out_t o(logic [1:0] st, logic irin, logic [7:0] rin, logic [7:0] rout,
                             logic din, logic gout, logic ain, logic gin, logic addsub,
                             logic done);
    out_t r;
    r.step = st; r.irin = irin; r.rin = rin; r.rout = rout; r.dinout = din;
    r.gout = gout; r.ain = ain; r.gin = gin; r.addsub = addsub; r.done = done;
    return r;
  endfunction

  function automatic vec_t v(logic run, logic [8:0] ir, logic gnz, out_t e);
    vec_t r;
    r.run = run; r.ir = ir; r.gnz = gnz; r.exp = e;
    return r;
  endfunction

  function automatic out_t sample();
    return {step, IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};
  endfunction

  // Reference model: expected outputs for a given step and inputs.
  function automatic out_t ref_out(int st, logic run, logic [8:0] ir, logic gnz);
    out_t r = '0;
    logic [2:0] op = ir[8:6];
    logic [7:0] xo = 8'b1 << ir[5:3];
    logic [7:0] yo = 8'b1 << ir[2:0];
    r.step = st[1:0];
    if (st == 0) r.irin = run;
    else if (st == 1) begin
      if (op == 3'd0) begin r.rout = yo; r.rin = xo; r.done = 1'b1; end
      else if (op == 3'd1) begin r.dinout = 1'b1; r.rin = xo; r.done = 1'b1; end
      else if (op == 3'd2 || op == 3'd3) begin r.rout = xo; r.ain = 1'b1; end
      else if (op == 3'd4) begin
        r.done = 1'b1;
        if (gnz) begin r.rout = yo; r.rin = xo; end
      end
      else r.done = 1'b1;
    end
    else if (st == 2) begin
      r.rout = yo; r.gin = 1'b1; r.addsub = (op == 3'd3);
    end
    else begin
      r.gout = 1'b1; r.rin = xo; r.done = 1'b1;
    end
    return r;
  endfunction

  function automatic int ref_next(int st, logic run, logic [8:0] ir);
    if (st == 0) return run ? 1 : 0;
    if (st == 1) return (ir[8:6] == 3'd2 || ir[8:6] == 3'd3) ? 2 : 0;
    if (st == 2) return 3;
    return 0;
  endfunction

  task automatic check_out(input string nm);
    out_t got, e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
    end else begin
      e   = exp_q.pop_front();
      got = sample();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", nm, got, e);
      end
    end
  endtask

  task automatic cyc(input logic run, input logic [8:0] ir, input logic gnz,
                     input out_t e, input string nm);
    @(posedge Clock);
    #1;
    Run  = run;
    IR   = ir;
    G_nz = gnz;
    exp_q.push_back(e);
    @(negedge Clock);
    check_out(nm);
  endtask

  localparam logic [8:0] I_MVI3  = 9'b001_011_000;
  localparam logic [8:0] I_MV    = 9'b000_001_101;
  localparam logic [8:0] I_SUB   = 9'b011_100_110;
  localparam logic [8:0] I_MVNZ  = 9'b100_000_001;
  localparam logic [8:0] I_RSV   = 9'b101_010_011;
  localparam logic [8:0] I_ADD22 = 9'b010_010_010;
  localparam logic [8:0] I_MV70  = 9'b000_111_000;

  initial begin
    int mstep;
    logic r_run, r_gnz;
    logic [8:0] r_ir;
    out_t e;

    Resetn = 1'b0;
    Run    = 1'b1;
    IR     = I_MVI3;
    G_nz   = 1'b0;

    // Reset held with Run=1: everything quiet.
    repeat (2) begin
      @(negedge Clock);
      exp_q.push_back(Z);
      check_out("reset_hold");
    end
    Resetn = 1'b1;
    Run    = 1'b0;

    tbl.push_back(v(1, 9'd0,   0, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, I_MVI3, 0, o(1, 0, 8'h08, 8'h00, 1, 0, 0, 0, 0, 1)));
    tbl.push_back(v(0, I_MVI3, 0, Z));
    tbl.push_back(v(1, I_MVI3, 0, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, I_MV,   0, o(1, 0, 8'h02, 8'h20, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(0, I_MV,   0, Z));
    tbl.push_back(v(1, I_MV,   0, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, I_SUB,  0, o(1, 0, 8'h00, 8'h10, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(0, I_SUB,  0, o(2, 0, 8'h00, 8'h40, 0, 0, 0, 1, 1, 0)));
    tbl.push_back(v(0, I_SUB,  0, o(3, 0, 8'h10, 8'h00, 0, 1, 0, 0, 0, 1)));
    tbl.push_back(v(0, I_SUB,  0, Z));
    tbl.push_back(v(1, I_SUB,  0, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, I_MVNZ, 0, o(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(1, I_MVNZ, 1, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, I_MVNZ, 1, o(1, 0, 8'h01, 8'h02, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(1, I_RSV,  1, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, I_RSV,  1, o(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(0, I_RSV,  1, Z));
    // add R2,R2 then mv R7,R0 with Run held high throughout.
    tbl.push_back(v(1, I_RSV,   0, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, I_ADD22, 0, o(1, 0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, I_ADD22, 0, o(2, 0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(v(1, I_ADD22, 0, o(3, 0, 8'h04, 8'h00, 0, 1, 0, 0, 0, 1)));
    tbl.push_back(v(1, I_ADD22, 0, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, I_MV70,  0, o(1, 0, 8'h80, 8'h01, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(0, I_MV70,  0, Z));

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].run, tbl[i].ir, tbl[i].gnz, tbl[i].exp, $sformatf("vec%0d", i));

    // Mid-instruction asynchronous reset during add T2.
    cyc(1, I_ADD22, 0, o(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "midrst_t0");
    cyc(0, I_ADD22, 0, o(1, 0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0), "midrst_t1");
    cyc(0, I_ADD22, 0, o(2, 0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0), "midrst_t2");
    #2;
    Resetn = 1'b0;
    #1;
    exp_q.push_back(Z);
    check_out("midrst_async");
    @(posedge Clock);
    #1;
    exp_q.push_back(Z);
    check_out("midrst_held");
    @(negedge Clock);
    Resetn = 1'b1;
    Run    = 1'b0;
    cyc(0, I_ADD22, 0, Z, "midrst_after");

    // Randomised run against the reference model.
    mstep = 0;
    r_ir  = 9'd0;
    for (int n = 0; n < 400; n++) begin
      @(posedge Clock);
      #1;
      if (mstep == 0) r_ir = 9'($urandom);
      r_run = 1'($urandom_range(0, 1));
      r_gnz = 1'($urandom_range(0, 1));
      Run   = r_run;
      IR    = r_ir;
      G_nz  = r_gnz;
      e     = ref_out(mstep, r_run, r_ir, r_gnz);
      exp_q.push_back(e);
      @(negedge Clock);
      check_out($sformatf("rand%0d", n));
      checks++;
      if (!$onehot0({Rout, Gout, DINout})) begin
        errors++;
        $display("FAIL bus_excl%0d: got Rout=%h Gout=%b DINout=%b required at most one driver",
                 n, Rout, Gout, DINout);
      end
      mstep = ref_next(mstep, r_run, r_ir);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
